// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions used by both the write and read controllers.
package fifo_pkg;

  localparam int unsigned FIFO_ADDR_WIDTH = 5;
  localparam int unsigned FIFO_DEPTH      = 1 << FIFO_ADDR_WIDTH;
  localparam int unsigned FIFO_PTR_WIDTH  = FIFO_ADDR_WIDTH + 1;

  // Code conversions run on a wide container; callers zero-extend and truncate,
  // which keeps the result exact for any pointer width up to FIFO_CODE_WIDTH.
  localparam int unsigned FIFO_CODE_WIDTH = 16;
  typedef logic [FIFO_CODE_WIDTH-1:0] fifo_code_t;

  function automatic fifo_code_t bin2gray(input fifo_code_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic fifo_code_t gray2bin(input fifo_code_t g);
    fifo_code_t b;
    b[FIFO_CODE_WIDTH-1] = g[FIFO_CODE_WIDTH-1];
    for (int i = FIFO_CODE_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_ptr_sync.sv
// Multi-flop synchronizer for a Gray-coded pointer crossing into the local clock domain.
module fifo_ptr_sync #(
  parameter int unsigned WIDTH       = 6,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Async FIFO write-domain controller: write pointer, full/almost-full/level status.
// FIFO_WR_OVERFLOW_STICKY_EN makes overflow hold until reset instead of pulsing.
module fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = FIFO_ADDR_WIDTH,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  wclk,
  input  logic                  hw_rst_n,
  input  logic                  write_enable,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [ADDR_WIDTH-1:0] afull_value,
  input  logic [ADDR_WIDTH:0]   rd_ptr_gray_async,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [ADDR_WIDTH:0]   wr_ptr_gray,
  output logic                  wfull,
  output logic                  wr_almost_full,
  output logic                  overflow,
  output logic [ADDR_WIDTH:0]   fifo_write_count,
  output logic [ADDR_WIDTH:0]   wr_level
);

  localparam int unsigned PW    = ADDR_WIDTH + 1;
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wgray_q, wgray_d;
  logic [PW-1:0] level_q, level_d;
  logic          wfull_q, wfull_d;
  logic          afull_q, afull_d;
  logic          overflow_q, overflow_d;

  logic [PW-1:0] rq_sync;
  logic [PW-1:0] rbin_s;
  logic [PW-1:0] free_slots;
  logic          acc;

  fifo_ptr_sync #(
    .WIDTH       (PW),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_rptr_sync (
    .clk   (wclk),
    .rst_n (hw_rst_n),
    .d_i   (rd_ptr_gray_async),
    .q_o   (rq_sync)
  );

  // Next-state pointer and status; full compares Gray codes with the two MSBs inverted.
  always_comb begin
    acc        = write_enable & ~wfull_q & hw_rst_n;
    wbin_d     = wbin_q + PW'(acc);
    wgray_d    = PW'(bin2gray(FIFO_CODE_WIDTH'(wbin_d)));
    rbin_s     = PW'(gray2bin(FIFO_CODE_WIDTH'(rq_sync)));
    level_d    = wbin_d - rbin_s;
    free_slots = PW'(DEPTH) - level_d;
    wfull_d    = (wgray_d == {~rq_sync[PW-1:PW-2], rq_sync[PW-3:0]});
    afull_d    = (free_slots <= PW'(afull_value));
`ifdef FIFO_WR_OVERFLOW_STICKY_EN
    overflow_d = overflow_q | (write_enable & wfull_q);
`else
    overflow_d = write_enable & wfull_q;
`endif
  end

  always_ff @(posedge wclk) begin
    if (!hw_rst_n) begin
      wbin_q     <= '0;
      wgray_q    <= '0;
      level_q    <= '0;
      wfull_q    <= 1'b0;
      afull_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wbin_q     <= wbin_d;
      wgray_q    <= wgray_d;
      level_q    <= level_d;
      wfull_q    <= wfull_d;
      afull_q    <= afull_d;
      overflow_q <= overflow_d;
    end
  end

  assign mem_we           = acc;
  assign mem_waddr        = wbin_q[ADDR_WIDTH-1:0];
  assign mem_wdata        = write_data;
  assign wr_ptr_gray      = wgray_q;
  assign wfull            = wfull_q;
  assign wr_almost_full   = afull_q;
  assign overflow         = overflow_q;
  assign fifo_write_count = wbin_q;
  assign wr_level         = level_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed self-checking bench for fifo_wr_ctrl at default parameters.
module tb_fifo_wr_ctrl;

  logic        wclk = 1'b0;
  logic        hw_rst_n;
  logic        write_enable;
  logic [31:0] write_data;
  logic [4:0]  afull_value;
  logic [5:0]  rd_ptr_gray_async;
  logic        mem_we;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic [5:0]  wr_ptr_gray;
  logic        wfull;
  logic        wr_almost_full;
  logic        overflow;
  logic [5:0]  fifo_write_count;
  logic [5:0]  wr_level;

  int errors = 0;
  int checks = 0;

  always #5 wclk = ~wclk;

  fifo_wr_ctrl dut (
    .wclk              (wclk),
    .hw_rst_n          (hw_rst_n),
    .write_enable      (write_enable),
    .write_data        (write_data),
    .afull_value       (afull_value),
    .rd_ptr_gray_async (rd_ptr_gray_async),
    .mem_we            (mem_we),
    .mem_waddr         (mem_waddr),
    .mem_wdata         (mem_wdata),
    .wr_ptr_gray       (wr_ptr_gray),
    .wfull             (wfull),
    .wr_almost_full    (wr_almost_full),
    .overflow          (overflow),
    .fifo_write_count  (fifo_write_count),
    .wr_level          (wr_level)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] g(input logic [5:0] b);
    return b ^ (b >> 1);
  endfunction

  // One rising edge, then settle on the falling edge for sampling/driving.
  task automatic step();
    @(posedge wclk);
    @(negedge wclk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".wr_ptr_gray"}, 64'(wr_ptr_gray), 64'd0);
    chk({tag, ".wfull"}, 64'(wfull), 64'd0);
    chk({tag, ".afull"}, 64'(wr_almost_full), 64'd0);
    chk({tag, ".overflow"}, 64'(overflow), 64'd0);
    chk({tag, ".count"}, 64'(fifo_write_count), 64'd0);
    chk({tag, ".level"}, 64'(wr_level), 64'd0);
  endtask

  initial begin
    logic [31:0] d;
    hw_rst_n          = 1'b0;
    write_enable      = 1'b1;
    write_data        = 32'hDEAD_BEEF;
    afull_value       = 5'd4;
    rd_ptr_gray_async = 6'd0;

    // Reset held with a write request pending
    @(negedge wclk);
    #1 chk("rst.mem_we", 64'(mem_we), 64'd0);
    step();
    step();
    chk_all_zero("rst");
    hw_rst_n     = 1'b1;
    write_enable = 1'b0;
    step();
    chk("idle.level", 64'(wr_level), 64'd0);

    // Fill with 32 writes, read pointer held at 0
    for (int i = 0; i < 32; i++) begin
      d            = 32'hA500_0000 | 32'(i);
      write_enable = 1'b1;
      write_data   = d;
      #1;
      chk("fill.mem_we", 64'(mem_we), 64'd1);
      chk("fill.waddr", 64'(mem_waddr), 64'(i));
      chk("fill.wdata", 64'(mem_wdata), 64'(d));
      step();
      chk("fill.gray", 64'(wr_ptr_gray), 64'(g(6'(i + 1))));
      chk("fill.level", 64'(wr_level), 64'(i + 1));
      if (i == 26) chk("afull.at27", 64'(wr_almost_full), 64'd0);
      if (i == 27) chk("afull.at28", 64'(wr_almost_full), 64'd1);
      if (i < 31)  chk("fill.notfull", 64'(wfull), 64'd0);
    end
    chk("full.wfull", 64'(wfull), 64'd1);
    chk("full.level", 64'(wr_level), 64'd32);
    chk("full.count", 64'(fifo_write_count), 64'd32);
    chk("full.gray", 64'(wr_ptr_gray), 64'b110000);
    chk("full.overflow", 64'(overflow), 64'd0);

    // 33rd write is rejected
    write_data = 32'h1234_5678;
    #1 chk("ovf.mem_we", 64'(mem_we), 64'd0);
    step();
    chk("ovf.pulse", 64'(overflow), 64'd1);
    chk("ovf.count", 64'(fifo_write_count), 64'd32);
    chk("ovf.gray", 64'(wr_ptr_gray), 64'b110000);
    write_enable = 1'b0;
    step();
`ifdef FIFO_WR_OVERFLOW_STICKY_EN
    chk("ovf.after", 64'(overflow), 64'd1);
`else
    chk("ovf.after", 64'(overflow), 64'd0);
`endif

    // Read pointer advances by one: wfull falls on the third edge
    rd_ptr_gray_async = 6'b000001;
    step();
    chk("rd.edge1.wfull", 64'(wfull), 64'd1);
    step();
    chk("rd.edge2.wfull", 64'(wfull), 64'd1);
    chk("rd.edge2.level", 64'(wr_level), 64'd32);
    step();
    chk("rd.edge3.wfull", 64'(wfull), 64'd0);
    chk("rd.edge3.level", 64'(wr_level), 64'd31);
    chk("rd.edge3.afull", 64'(wr_almost_full), 64'd1);

    // Reset, then 64 writes with the read pointer tracking the writes
    hw_rst_n          = 1'b0;
    rd_ptr_gray_async = 6'd0;
    step();
    hw_rst_n = 1'b1;
    chk_all_zero("rst2");
    for (int i = 0; i < 64; i++) begin
      write_enable      = 1'b1;
      write_data        = 32'(i * 3);
      rd_ptr_gray_async = g(6'(i));
      #1 chk("wrap.waddr", 64'(mem_waddr), 64'(i % 32));
      step();
      chk("wrap.notfull", 64'(wfull), 64'd0);
    end
    chk("wrap.count", 64'(fifo_write_count), 64'd0);
    chk("wrap.gray", 64'(wr_ptr_gray), 64'd0);

    // Reset asserted mid-burst with write_enable still high
    hw_rst_n          = 1'b0;
    rd_ptr_gray_async = 6'd0;
    #1 chk("midrst.mem_we", 64'(mem_we), 64'd0);
    step();
    chk_all_zero("midrst");
    chk("midrst.mem_we_hold", 64'(mem_we), 64'd0);
    hw_rst_n = 1'b1;
    #1 chk("post.mem_we", 64'(mem_we), 64'd1);
    chk("post.waddr", 64'(mem_waddr), 64'd0);
    step();
    chk("post.count", 64'(fifo_write_count), 64'd1);
    chk("post.gray", 64'(wr_ptr_gray), 64'd1);
    write_enable = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_wr_ctrl.md
# fifo_wr_ctrl

Write-domain controller for the asynchronous FIFO; the counterpart of the read-side logic. It accepts write requests on `wclk`, drives the dual-port memory write port and publishes the Gray-coded write pointer to the read domain. It also synchronizes the read domain's Gray pointer and derives full, almost-full, overflow, write count and level status. All logic sits in the `wclk` domain; the only crossing is the synchronized read-pointer input.

## Interface
Parameters:
- `DATA_WIDTH`, default 32: write data width.
- `ADDR_WIDTH`, default 5: memory address width; depth is 2**ADDR_WIDTH = 32.
- `SYNC_STAGES`, default 2: flop stages on the read-pointer synchronizer; must be ≥ 2.

Ports (widths shown for the default parameters):
- Clock and reset: one clock, `wclk`; reset `hw_rst_n` is synchronous, active-low.
- `wclk` input 1: write-domain clock.
- `hw_rst_n` input 1: reset; synchronous, active-low.
- `write_enable` input 1: write request for the current cycle.
- `write_data` input 32: data to write.
- `afull_value` input 5: almost-full threshold, expressed as free slots.
- `rd_ptr_gray_async` input 6: read-domain Gray pointer; asynchronous to `wclk`.
- `mem_we` output 1: memory write strobe.
- `mem_waddr` output 5: memory write address.
- `mem_wdata` output 32: memory write data.
- `wr_ptr_gray` output 6: registered Gray write pointer, sent to the read domain.
- `wfull` output 1: FIFO full.
- `wr_almost_full` output 1: free slots ≤ `afull_value`.
- `overflow` output 1: a write was attempted while full.
- `fifo_write_count` output 6: accepted writes modulo 64.
- `wr_level` output 6: occupancy as seen from the write domain, range 0..32.

## Operation
- Accepted write: `acc = write_enable & ~wfull & hw_rst_n`.
- Memory port outputs are combinational:
  - `mem_we = acc`.
  - `mem_waddr = wbin[4:0]`.
  - `mem_wdata = write_data`.
- Write pointer:
  - Internal `wbin` is 6 bits; it increments by 1 on `acc` and wraps 63→0.
  - `wr_ptr_gray` is registered as `wbin_next ^ (wbin_next >> 1)`.
  - `fifo_write_count` equals `wbin`.
- Read-pointer synchronizer:
  - A `SYNC_STAGES`-deep flop chain on `rd_ptr_gray_async` produces `rq_sync`.
  - `rbin_s = gray2bin(rq_sync)`.
- Next-state status:
  - `level_next = wbin_next - rbin_s`, computed modulo 64.
  - `wfull` is registered as `wgray_next == {~rq_sync[5:4], rq_sync[3:0]}`. This is equivalent to `level_next == 32`.
  - `wr_level` is registered as `level_next`.
  - `wr_almost_full` is registered as `(32 - level_next) <= afull_value`. With `afull_value = 0` it behaves as full.
- `overflow` is registered as `write_enable & wfull`: a one-cycle pulse per rejected write (see Configuration). A rejected write does not change the pointer or memory.
- Full detection is pessimistic. Because the read pointer lags, `wfull` may stay high for a few cycles after a read; it never deasserts early.
- Simultaneous write-while-full and read-pointer advance: the write is rejected, `overflow` is flagged, and `wfull` clears on a later edge.

## Timing
- Reset: when `hw_rst_n` is sampled low at a `wclk` rising edge, all registers clear on that edge, including every synchronizer flop. Reset values:
  - `wr_ptr_gray = 0`, `wfull = 0`, `wr_almost_full = 0`.
  - `overflow = 0`, `fifo_write_count = 0`, `wr_level = 0`.
  - `mem_we = 0` for as long as `hw_rst_n` is low.
- Reset mid-operation: pointers return to 0 and buffered data is discarded. The system resets the read side in the same window.
- Write path: `mem_we` is combinational in the request cycle. `wr_ptr_gray`, `wr_level`, `wfull` and `wr_almost_full` reflect that write after the same rising edge, with zero extra latency.
- Read path: a `rd_ptr_gray_async` value stable before edge k appears in `wfull`/`wr_level` after edge k+SYNC_STAGES. With the default, that is 3 edges.
- Status in the cycle after the 32nd outstanding write: `wfull = 1`, `mem_we = 0`.

## Configuration
- Macro: `FIFO_WR_OVERFLOW_STICKY_EN`.
- Defined: `overflow` is sticky. It sets on the first rejected write and holds until reset.
- Undefined: `overflow` pulses for one cycle per rejected write, as described in Operation.

## Structure
- Package `fifo_pkg` holds the shared definitions, also used by the read-side logic:
  - `FIFO_DEPTH`, `FIFO_ADDR_WIDTH`, `FIFO_PTR_WIDTH`.
  - Functions `bin2gray` and `gray2bin`.
- Sub-module `fifo_ptr_sync`:
  - Parameterized width and `SYNC_STAGES`.
  - Synchronous active-low reset.
  - Reused by the read side.

## Test plan
- Reset, hold `rd_ptr_gray_async = 0`, issue 32 writes → after the 32nd edge: `wfull = 1`, `wr_level = 32`, `fifo_write_count = 32`, `wr_ptr_gray = 6'b110000`.
- 33rd write while full → `mem_we = 0`, `overflow` pulses one cycle (sticky when `FIFO_WR_OVERFLOW_STICKY_EN` is defined), pointer unchanged.
- `afull_value = 4` → `wr_almost_full = 0` after 27 writes; `wr_almost_full = 1` after 28 writes.
- Full, then drive `rd_ptr_gray_async = 6'b000001` → `wfull` falls exactly 3 edges later and `wr_level = 31`.
- Write 64 words while the read pointer tracks writes → `fifo_write_count` wraps to 0, `wr_ptr_gray = 0`, `wfull` never asserts.
- Assert `hw_rst_n = 0` mid-burst with `write_enable = 1` → `mem_we = 0`, and all outputs are 0 after the next edge.
